// File: rtl/axi_lite_reg_bank_pkg.sv
// Shared constants and types for the register bank: word indices, register count,
// default VERSION value and the transaction FSM state encoding.
package axi_lite_reg_bank_pkg;

    localparam logic [2:0] REG_CONTROL  = 3'd0;
    localparam logic [2:0] REG_CMD      = 3'd1;
    localparam logic [2:0] REG_STATUS   = 3'd2;
    localparam logic [2:0] REG_IRQ_PEND = 3'd3;
    localparam logic [2:0] REG_IRQ_EN   = 3'd4;
    localparam logic [2:0] REG_SCRATCH  = 3'd5;
    localparam logic [2:0] REG_VERSION  = 3'd6;

    localparam int REG_COUNT = 7;

    localparam logic [31:0] DEFAULT_VERSION = 32'h0001_0000;

    typedef enum logic [0:0] {
        ST_IDLE         = 1'b0,
        ST_WAIT_RELEASE = 1'b1
    } state_t;

endpackage

// File: rtl/axi_lite_reg_bank_if.sv
// Register access bus: level requests from the master, one-cycle acknowledge/valid pulses
// from the slave, and a shared address for both directions.
//
// Handshake: the master raises i_reg_in_rdy (write) or i_reg_out_req (read) and holds it
// until it sees o_reg_in_ack_stb / o_reg_out_rdy; it must then drop the request before the
// next one is accepted. o_reg_invalid_addr is valid alongside either pulse.
interface axi_lite_reg_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_reg_in_rdy;
    logic                  o_reg_in_ack_stb;
    logic [ADDR_WIDTH-1:0] i_reg_address;
    logic [DATA_WIDTH-1:0] i_reg_in_data;
    logic                  i_reg_out_req;
    logic                  o_reg_out_rdy;
    logic [DATA_WIDTH-1:0] o_reg_out_data;
    logic                  o_reg_invalid_addr;

    modport master (
        output i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
        input  o_reg_in_ack_stb, o_reg_out_rdy, o_reg_out_data, o_reg_invalid_addr
    );

    modport slave (
        input  i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
        output o_reg_in_ack_stb, o_reg_out_rdy, o_reg_out_data, o_reg_invalid_addr
    );
endinterface

// File: rtl/axi_lite_reg_bank_irq.sv
// Interrupt block: W1C pending bits with set-priority, enable mask, and a registered
// interrupt line computed from the post-update pending/enable values.
module reg_bank_irq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] irq_event,
    input  logic                  pend_we,
    input  logic                  en_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] pend,
    output logic [DATA_WIDTH-1:0] en,
    output logic                  irq
);
    logic [DATA_WIDTH-1:0] w1c_mask;
    logic [DATA_WIDTH-1:0] pend_next;
    logic [DATA_WIDTH-1:0] en_next;

    // OR-ing the event in after the clear makes a same-cycle set win over the clear.
    assign w1c_mask  = pend_we ? wdata : '0;
    assign pend_next = (pend & ~w1c_mask) | irq_event;
    assign en_next   = en_we ? wdata : en;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            en   <= '0;
            irq  <= 1'b0;
        end else begin
            pend <= pend_next;
            en   <= en_next;
            irq  <= |(pend_next & en_next);
        end
    end
endmodule

// File: rtl/axi_lite_reg_bank.sv
// Small control/status register bank: address decode, request FSM and the CONTROL,
// CMD, STATUS, SCRATCH and VERSION registers; interrupt state lives in reg_bank_irq.
module axi_lite_reg_bank
    import axi_lite_reg_bank_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] VERSION    = DATA_WIDTH'(DEFAULT_VERSION)
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_lite_reg_bank_if.slave    bus,
    output logic [DATA_WIDTH-1:0] o_control,
    output logic [DATA_WIDTH-1:0] o_cmd_pulse,
    input  logic [DATA_WIDTH-1:0] i_status,
    input  logic [DATA_WIDTH-1:0] i_irq_event,
    output logic                  o_irq,
    output state_t                fsm_state
);
    state_t                state;
    state_t                state_next;
    logic                  write_go;
    logic                  read_go;
    logic [ADDR_WIDTH-3:0] index;
    logic [2:0]            sel;
    logic                  in_map;
    logic                  wr_invalid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] scratch;
    logic [DATA_WIDTH-1:0] irq_pend;
    logic [DATA_WIDTH-1:0] irq_en;
    logic                  unused_addr_bits;

    // Byte-lane bits are irrelevant: all accesses are full-word.
    assign unused_addr_bits = ^bus.i_reg_address[1:0];
    assign index            = bus.i_reg_address[ADDR_WIDTH-1:2];
    assign sel              = index[2:0];
    assign in_map           = ((index >> 3) == '0) && (32'(sel) < REG_COUNT);
    assign wr_invalid       = !in_map || (sel == REG_STATUS) || (sel == REG_VERSION);
    assign fsm_state        = state;

    always_comb begin
        state_next = state;
        write_go   = 1'b0;
        read_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_reg_in_rdy) begin
                    write_go   = 1'b1;
                    state_next = ST_WAIT_RELEASE;
                end else if (bus.i_reg_out_req) begin
                    read_go    = 1'b1;
                    state_next = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!bus.i_reg_in_rdy && !bus.i_reg_out_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (in_map) begin
            case (sel)
                REG_CONTROL:  rd_data = o_control;
                REG_STATUS:   rd_data = i_status;
                REG_IRQ_PEND: rd_data = irq_pend;
                REG_IRQ_EN:   rd_data = irq_en;
                REG_SCRATCH:  rd_data = scratch;
                REG_VERSION:  rd_data = VERSION;
                default:      rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            bus.o_reg_in_ack_stb   <= 1'b0;
            bus.o_reg_out_rdy      <= 1'b0;
            bus.o_reg_out_data     <= '0;
            bus.o_reg_invalid_addr <= 1'b0;
            o_cmd_pulse            <= '0;
            o_control              <= '0;
            scratch                <= '0;
        end else begin
            state                <= state_next;
            bus.o_reg_in_ack_stb <= write_go;
            bus.o_reg_out_rdy    <= read_go;
            o_cmd_pulse          <= (write_go && in_map && sel == REG_CMD) ? bus.i_reg_in_data : '0;
            if (write_go) begin
                bus.o_reg_invalid_addr <= wr_invalid;
                if (in_map && sel == REG_CONTROL) o_control <= bus.i_reg_in_data;
                if (in_map && sel == REG_SCRATCH) scratch   <= bus.i_reg_in_data;
            end
            if (read_go) begin
                bus.o_reg_out_data     <= rd_data;
                bus.o_reg_invalid_addr <= !in_map;
            end
        end
    end

    reg_bank_irq #(.DATA_WIDTH(DATA_WIDTH)) u_irq (
        .clk       (clk),
        .rst       (rst),
        .irq_event (i_irq_event),
        .pend_we   (write_go && in_map && sel == REG_IRQ_PEND),
        .en_we     (write_go && in_map && sel == REG_IRQ_EN),
        .wdata     (bus.i_reg_in_data),
        .pend      (irq_pend),
        .en        (irq_en),
        .irq       (o_irq)
    );
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank: register access, CMD pulses, IRQ W1C/set
// priority, invalid addresses, simultaneous requests and reset abort.
module tb_axi_lite_reg_bank;
    import axi_lite_reg_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] o_control;
    logic [31:0] o_cmd_pulse;
    logic [31:0] i_status;
    logic [31:0] i_irq_event;
    logic        o_irq;
    state_t      fsm_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_cmd;
    int          last_cmd_cycles;

    axi_lite_reg_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_reg_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_control   (o_control),
        .o_cmd_pulse (o_cmd_pulse),
        .i_status    (i_status),
        .i_irq_event (i_irq_event),
        .o_irq       (o_irq),
        .fsm_state   (fsm_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a write, hold it for 'hold' cycles, count acknowledges and CMD activity.
    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data, input int hold,
                             input logic exp_inv, input string tag);
        int          acks = 0;
        int          first_ack = -1;
        int          cmd_cycles = 0;
        logic [31:0] cmd_at_ack = '0;
        bus.i_reg_address = addr;
        bus.i_reg_in_data = data;
        bus.i_reg_in_rdy  = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_reg_in_ack_stb === 1'b1) begin
                acks++;
                if (first_ack < 0) first_ack = c;
                cmd_at_ack = o_cmd_pulse;
                check({tag, " invalid"}, 32'(bus.o_reg_invalid_addr), 32'(exp_inv));
            end
            if (o_cmd_pulse !== '0) cmd_cycles++;
        end
        bus.i_reg_in_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus.o_reg_in_ack_stb === 1'b1) acks++;
        if (o_cmd_pulse !== '0) cmd_cycles++;
        check({tag, " ack count"}, 32'(acks), 32'd1);
        check({tag, " ack latency"}, 32'(first_ack), 32'd0);
        last_cmd        = cmd_at_ack;
        last_cmd_cycles = cmd_cycles;
    endtask

    // Drive a read held for 3 cycles; expected data goes through the scoreboard queue.
    task automatic read_reg(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic exp_inv, input string tag);
        int          rdys = 0;
        int          lat = -1;
        logic [31:0] got = '0;
        logic        inv = 1'b0;
        logic [31:0] exp;
        exp_q.push_back(exp_data);
        bus.i_reg_address = addr;
        bus.i_reg_out_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_reg_out_rdy === 1'b1) begin
                rdys++;
                if (lat < 0) begin
                    lat = c;
                    got = bus.o_reg_out_data;
                    inv = bus.o_reg_invalid_addr;
                end
            end
        end
        bus.i_reg_out_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus.o_reg_out_rdy === 1'b1) rdys++;
        check({tag, " rdy count"}, 32'(rdys), 32'd1);
        check({tag, " rdy latency"}, 32'(lat), 32'd0);
        exp = exp_q.pop_front();
        check({tag, " data"}, got, exp);
        check({tag, " invalid"}, 32'(inv), 32'(exp_inv));
        check({tag, " data held"}, bus.o_reg_out_data, exp);
    endtask

    initial begin
        int acks;
        int rdys;

        rst               = 1'b1;
        bus.i_reg_in_rdy  = 1'b0;
        bus.i_reg_out_req = 1'b0;
        bus.i_reg_address = '0;
        bus.i_reg_in_data = '0;
        i_status          = 32'h1234_5678;
        i_irq_event       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("reset ack", 32'(bus.o_reg_in_ack_stb), 32'd0);
        check("reset out_rdy", 32'(bus.o_reg_out_rdy), 32'd0);
        check("reset out_data", bus.o_reg_out_data, 32'd0);
        check("reset invalid", 32'(bus.o_reg_invalid_addr), 32'd0);
        check("reset control", o_control, 32'd0);
        check("reset cmd", o_cmd_pulse, 32'd0);
        check("reset irq", 32'(o_irq), 32'd0);
        check("reset state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // CONTROL round trip with the write held for three cycles
        write_reg(32'h00, 32'hDEAD_BEEF, 3, 1'b0, "wr control");
        check("control out", o_control, 32'hDEAD_BEEF);
        read_reg(32'h00, 32'hDEAD_BEEF, 1'b0, "rd control");

        // CMD pulse
        write_reg(32'h04, 32'h0000_0005, 3, 1'b0, "wr cmd");
        check("cmd pulse value", last_cmd, 32'h5);
        check("cmd pulse cycles", 32'(last_cmd_cycles), 32'd1);
        read_reg(32'h04, 32'h0, 1'b0, "rd cmd");

        // SCRATCH, low address bits ignored on read
        write_reg(32'h14, 32'hA5A5_5A5A, 2, 1'b0, "wr scratch");
        read_reg(32'h17, 32'hA5A5_5A5A, 1'b0, "rd scratch lowbits");

        // IRQ: enable bit 1, pulse event bit 1
        write_reg(32'h10, 32'h2, 2, 1'b0, "wr irq_en");
        check("irq before event", 32'(o_irq), 32'd0);
        i_irq_event = 32'h2;
        @(posedge clk);
        @(negedge clk);
        i_irq_event = '0;
        check("irq after event", 32'(o_irq), 32'd1);

        // W1C in the same cycle as a new event: set wins
        bus.i_reg_address = 32'h0C;
        bus.i_reg_in_data = 32'h2;
        bus.i_reg_in_rdy  = 1'b1;
        i_irq_event       = 32'h2;
        @(posedge clk);
        @(negedge clk);
        i_irq_event = '0;
        check("w1c+set ack", 32'(bus.o_reg_in_ack_stb), 32'd1);
        check("w1c+set irq", 32'(o_irq), 32'd1);
        bus.i_reg_in_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w1c+set irq hold", 32'(o_irq), 32'd1);
        read_reg(32'h0C, 32'h2, 1'b0, "rd pend set");

        write_reg(32'h0C, 32'h2, 2, 1'b0, "wr w1c");
        check("irq after w1c", 32'(o_irq), 32'd0);
        read_reg(32'h0C, 32'h0, 1'b0, "rd pend clear");

        // invalid / read-only addresses
        read_reg(32'h1C, 32'h0, 1'b1, "rd invalid");
        write_reg(32'h08, 32'hFFFF_FFFF, 2, 1'b1, "wr status");
        read_reg(32'h08, 32'h1234_5678, 1'b0, "rd status");
        write_reg(32'h18, 32'hFFFF_FFFF, 2, 1'b1, "wr version");
        read_reg(32'h18, 32'h0001_0000, 1'b0, "rd version");
        write_reg(32'h40, 32'h0BAD_0BAD, 2, 1'b1, "wr far");
        check("control after bad writes", o_control, 32'hDEAD_BEEF);

        // simultaneous write and read: write first, read only after full release
        acks = 0;
        rdys = 0;
        bus.i_reg_address = 32'h14;
        bus.i_reg_in_data = 32'h0000_0077;
        bus.i_reg_in_rdy  = 1'b1;
        bus.i_reg_out_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("both first ack", 32'(bus.o_reg_in_ack_stb), 32'd1);
        check("both first rdy", 32'(bus.o_reg_out_rdy), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_reg_in_ack_stb === 1'b1) acks++;
            if (bus.o_reg_out_rdy === 1'b1) rdys++;
        end
        bus.i_reg_in_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_reg_in_ack_stb === 1'b1) acks++;
            if (bus.o_reg_out_rdy === 1'b1) rdys++;
        end
        bus.i_reg_out_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus.o_reg_out_rdy === 1'b1) rdys++;
        check("both extra acks", 32'(acks), 32'd0);
        check("both early rdys", 32'(rdys), 32'd0);
        read_reg(32'h14, 32'h0000_0077, 1'b0, "rd after both");

        // reset during a held write: aborted, then served once afresh
        acks = 0;
        bus.i_reg_address = 32'h00;
        bus.i_reg_in_data = 32'hCAFE_0001;
        bus.i_reg_in_rdy  = 1'b1;
        rst               = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_reg_in_ack_stb === 1'b1) acks++;
        end
        check("rst ack count", 32'(acks), 32'd0);
        check("rst control", o_control, 32'd0);
        check("rst out_data", bus.o_reg_out_data, 32'd0);
        check("rst invalid", 32'(bus.o_reg_invalid_addr), 32'd0);
        check("rst cmd", o_cmd_pulse, 32'd0);
        check("rst irq", 32'(o_irq), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_reg_in_ack_stb === 1'b1) acks++;
        end
        bus.i_reg_in_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus.o_reg_in_ack_stb === 1'b1) acks++;
        check("post-rst ack count", 32'(acks), 32'd1);
        check("post-rst control", o_control, 32'hCAFE_0001);
        read_reg(32'h10, 32'h0, 1'b0, "rd irq_en after rst");
        read_reg(32'h14, 32'h0, 1'b0, "rd scratch after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
